// File: rtl/div_unit_pkg.sv
// div_unit_pkg: shared constants and types for the iterative divider.
// Op encodings, FSM states and default widths.
package div_unit_pkg;

  localparam int DIV_XLEN  = 32;
  localparam int DIV_CNT_W = 5;

  localparam logic [1:0] DIVOP_DIV  = 2'b00;
  localparam logic [1:0] DIVOP_DIVU = 2'b01;
  localparam logic [1:0] DIVOP_REM  = 2'b10;
  localparam logic [1:0] DIVOP_REMU = 2'b11;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_CALC = 2'b01,
    DIV_FIX  = 2'b10,
    DIV_DONE = 2'b11
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// div_step: one radix-2 restoring iteration.
// Shifts {rem,quo} left and keeps the trial subtract when non-negative.
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] dvs_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quo_o
);

  logic [XLEN:0] shl;
  logic [XLEN:0] trial;

  // 33-bit trial subtract; bit XLEN is the borrow
  always_comb begin
    shl   = {rem_i, quo_i[XLEN-1]};
    trial = shl - {1'b0, dvs_i};
    if (!trial[XLEN]) begin
      rem_o = trial[XLEN-1:0];
      quo_o = {quo_i[XLEN-2:0], 1'b1};
    end else begin
      rem_o = shl[XLEN-1:0];
      quo_o = {quo_i[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_unit.sv
// div_unit: multi-cycle DIV/DIVU/REM/REMU for the EX stage.
// Setup cycle, 32 restoring iterations, sign fix, one-cycle done.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int XLEN  = DIV_XLEN,
  parameter int CNT_W = DIV_CNT_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  div_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [XLEN-1:0] res_q, res_d;
  logic setup_q, setup_d;
  logic sgn_q, sgn_d;
  logic negq_q, negq_d;
  logic negr_q, negr_d;
  logic isrem_q, isrem_d;
  logic [XLEN-1:0] step_rem;
  logic [XLEN-1:0] step_quo;

  div_step #(.XLEN(XLEN)) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dvs_i (dvs_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      res_q   <= '0;
      setup_q <= 1'b0;
      sgn_q   <= 1'b0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      isrem_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      res_q   <= res_d;
      setup_q <= setup_d;
      sgn_q   <= sgn_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      isrem_q <= isrem_d;
    end
  end

  // Next-state and datapath control; the first CALC cycle
  // turns the raw operands into magnitudes off the accept path
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    res_d   = res_q;
    setup_d = setup_q;
    sgn_d   = sgn_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    isrem_d = isrem_q;
    unique case (state_q)
      DIV_IDLE: begin
        if (start && !flush) begin
          if (b == '0) begin
            res_d   = op[1] ? a : '1;
            state_d = DIV_DONE;
          end else if (!op[0] && a == MIN_NEG && b == '1) begin
            res_d   = op[1] ? '0 : MIN_NEG;
            state_d = DIV_DONE;
          end else begin
            quo_d   = a;
            dvs_d   = b;
            rem_d   = '0;
            cnt_d   = '0;
            setup_d = 1'b1;
            sgn_d   = !op[0];
            negq_d  = !op[0] & (a[XLEN-1] ^ b[XLEN-1]);
            negr_d  = !op[0] & a[XLEN-1];
            isrem_d = op[1];
            state_d = DIV_CALC;
          end
        end
      end
      DIV_CALC: begin
        if (flush) begin
          setup_d = 1'b0;
          state_d = DIV_IDLE;
        end else if (setup_q) begin
          setup_d = 1'b0;
          if (sgn_q && quo_q[XLEN-1]) quo_d = -quo_q;
          if (sgn_q && dvs_q[XLEN-1]) dvs_d = -dvs_q;
        end else begin
          rem_d = step_rem;
          quo_d = step_quo;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == {CNT_W{1'b1}}) state_d = DIV_FIX;
        end
      end
      DIV_FIX: begin
        if (flush) begin
          state_d = DIV_IDLE;
        end else begin
          if (isrem_q) res_d = negr_q ? -rem_q : rem_q;
          else         res_d = negq_q ? -quo_q : quo_q;
          state_d = DIV_DONE;
        end
      end
      DIV_DONE: state_d = DIV_IDLE;
      default:  state_d = DIV_IDLE;
    endcase
  end

  // Status decode; stall covers the accept cycle combinationally
  always_comb begin
    busy   = (state_q == DIV_CALC) || (state_q == DIV_FIX);
    done   = (state_q == DIV_DONE);
    stall  = busy || ((state_q == DIV_IDLE) && start && !flush);
    result = res_q;
  end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed + random checks of div_unit with a result queue.
// Expected values come from constants or a native-arithmetic model.
module tb_div_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        stall;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int checks;
  int failures;
  logic [31:0] exp_q[$];

  div_unit dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .flush  (flush),
    .stall  (stall),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] o,
                                        input logic [31:0] x,
                                        input logic [31:0] y);
    logic [31:0] r;
    if (y == 32'd0) r = o[1] ? x : 32'hFFFF_FFFF;
    else if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)
      r = o[1] ? 32'd0 : 32'h8000_0000;
    else begin
      case (o)
        2'b00:   r = 32'($signed(x) / $signed(y));
        2'b01:   r = x / y;
        2'b10:   r = 32'($signed(x) % $signed(y));
        default: r = x % y;
      endcase
    end
    return r;
  endfunction

  // Issue one op, scramble inputs and poke start while busy,
  // then wait (bounded) for done and compare against the queue.
  task automatic run_op(input string tag, input logic [1:0] o,
                        input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] e, input int lat);
    int n;
    logic st_ok;
    logic [31:0] got;
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    exp_q.push_back(e);
    #1 chk({tag, " stall_accept"}, {31'd0, stall}, 32'd1);
    n = 0;
    st_ok = 1'b1;
    while (n < 60) begin
      @(posedge clk);
      n++;
      #1;
      start = 1'b0;
      if (n == 1) begin
        a = $urandom; b = $urandom; op = 2'($urandom);
      end
      if (n == 5) start = 1'b1;
      if (done) break;
      if (!stall) st_ok = 1'b0;
    end
    start = 1'b0;
    chk({tag, " latency"}, 32'(n), 32'(lat));
    chk({tag, " stall_busy"}, {31'd0, st_ok}, 32'd1);
    got = exp_q.pop_front();
    chk({tag, " result"}, result, got);
    chk({tag, " stall_done"}, {31'd0, stall}, 32'd0);
    @(posedge clk);
    #1 chk({tag, " done_pulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int n;
    logic seen;
    logic [1:0] ro;
    logic [31:0] ra;
    logic [31:0] rb;
    int rl;
    checks = 0;
    failures = 0;
    rst = 1'b0; start = 1'b0; flush = 1'b0;
    op = 2'b00; a = '0; b = '0;
    #12;
    chk("rst result", result, 32'd0);
    chk("rst done", {31'd0, done}, 32'd0);
    chk("rst busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    chk("idle stall", {31'd0, stall}, 32'd0);

    run_op("div_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 35);
    run_op("rem_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 35);
    run_op("divu_16", 2'b01, 32'hFFFF_FFFF, 32'd16, 32'h0FFF_FFFF, 35);

    // abort in CALC: no done, result keeps prior value
    @(negedge clk);
    op = 2'b00; a = 32'd100; b = 32'd7; start = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1 start = 1'b0;
      if (done) seen = 1'b1;
    end
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    chk("abort busy", {31'd0, busy}, 32'd0);
    chk("abort result", result, 32'h0FFF_FFFF);
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1 if (done) seen = 1'b1;
    end
    chk("abort no_done", {31'd0, seen}, 32'd0);
    run_op("div_100_7", 2'b00, 32'd100, 32'd7, 32'd14, 35);

    run_op("remu_16", 2'b11, 32'hFFFF_FFFF, 32'd16, 32'h0000_000F, 35);
    run_op("div_by0", 2'b00, 32'd123, 32'd0, 32'hFFFF_FFFF, 1);
    run_op("remu_by0", 2'b11, 32'd123, 32'd0, 32'd123, 1);
    run_op("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF,
           32'h8000_0000, 1);
    run_op("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);

    // start together with flush in IDLE is dropped
    @(negedge clk);
    op = 2'b01; a = 32'd9; b = 32'd3; start = 1'b1; flush = 1'b1;
    #1 chk("stflush stall", {31'd0, stall}, 32'd0);
    @(posedge clk);
    #1 start = 1'b0; flush = 1'b0;
    chk("stflush busy", {31'd0, busy}, 32'd0);
    chk("stflush done", {31'd0, done}, 32'd0);

    // flush during DONE does not cancel the pulse
    @(negedge clk);
    op = 2'b00; a = 32'd5; b = 32'd0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; flush = 1'b1;
    chk("dflush done", {31'd0, done}, 32'd1);
    chk("dflush result", result, 32'hFFFF_FFFF);
    @(posedge clk);
    #1 flush = 1'b0;
    chk("dflush after", {31'd0, done}, 32'd0);

    // async reset mid-divide
    @(negedge clk);
    op = 2'b00; a = 32'd1000; b = 32'd3; start = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1 start = 1'b0;
    end
    #2 rst = 1'b0;
    #1;
    chk("arst result", result, 32'd0);
    chk("arst busy", {31'd0, busy}, 32'd0);
    chk("arst stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    seen = 1'b0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1 if (done) seen = 1'b1;
    end
    chk("arst no_done", {31'd0, seen}, 32'd0);

    // random mixed-sign ops against the native model
    for (int i = 0; i < 8; i++) begin
      ro = 2'($urandom);
      ra = $urandom;
      rb = (i == 3) ? 32'd0 : ((i == 5) ? 32'hFFFF_FFFF : $urandom >> (i * 3));
      if (i == 5) ra = 32'h8000_0000;
      rl = (rb == 0 || (!ro[0] && ra == 32'h8000_0000 &&
            rb == 32'hFFFF_FFFF)) ? 1 : 35;
      run_op("rand", ro, ra, rb, model(ro, ra, rb), rl);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative radix-2 restoring divider in the EX stage, alongside the combinational ALU.
- Executes DIV/DIVU/REM/REMU over multiple cycles, so divide is no longer a single-cycle combinational path.
- Raises a stall to the hazard logic while working; delivers a registered 32-bit result into the EX-stage result mux / EX/MEM register.

Parameters:
- XLEN, 32, operand and result width.
- CNT_W, 5, iteration counter width (log2 XLEN).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- op  in  2  op[0]=1 unsigned, op[1]=1 remainder (00 DIV, 01 DIVU, 10 REM, 11 REMU).
- a  in  XLEN  dividend, from ID/EX forwarded operand.
- b  in  XLEN  divisor.
- flush  in  1  synchronous abort from branch/hazard unit.
- stall  out  1  holds PC, IF/ID and ID/EX while the divide is pending.
- busy  out  1  high in CALC and FIX.
- done  out  1  one-cycle pulse; result valid.
- result  out  XLEN  quotient or remainder; registered, held until next accepted start.

Behaviour:
- Reset (rst=0, async): state=IDLE, result=0, done=0, busy=0, counter=0, internal regs=0. Reset mid-operation discards the operation; no done pulse.
- States: IDLE, CALC, FIX, DONE.
- IDLE, start=1, flush=0:
  - b==0: result = op[1] ? a : 32'hFFFFFFFF, for signed and unsigned alike; go to DONE.
  - Signed (op[0]=0), a==32'h80000000, b==32'hFFFFFFFF: result = op[1] ? 0 : 32'h80000000; go to DONE.
  - Otherwise: latch magnitudes (|a|, |b| if signed, raw if unsigned), neg_q = signed & (a[31]^b[31]), neg_r = signed & a[31], op[1]; clear remainder accumulator; counter=0; go to CALC.
- CALC, one iteration per cycle:
  - {rem,quo} shifted left 1.
  - Trial = rem - divisor (33-bit); if non-negative, rem = trial and quo LSB = 1.
  - counter increments; after the 32nd iteration (counter==31) go to FIX.
- FIX:
  - result = op[1] ? (neg_r ? -rem : rem) : (neg_q ? -quo : quo).
  - Go to DONE.
- DONE: done=1 for exactly this cycle, then unconditionally back to IDLE. start is ignored in DONE.
- Latency, start sampled at edge N:
  - Normal path: done high in cycle after edge N+34 (1 setup + 32 CALC + 1 FIX).
  - Special cases: done high in cycle after edge N.
- stall = (state==IDLE & start & ~flush) | CALC | FIX. stall is combinational; it drops in the DONE cycle so the pipeline advances with the result.
- busy = CALC | FIX, registered state decode.
- start outside IDLE: ignored. Operands are captured only at acceptance; later changes on a/b/op have no effect.
- flush:
  - In CALC or FIX: return to IDLE next edge; no done; result unchanged.
  - In IDLE together with start: flush wins; nothing accepted.
  - In DONE: done still completes this cycle.
- Results match RISC-V M-extension semantics bit-exactly, including all corner cases above.

Decomposition:
- defines.v gets the op encodings: DIVOP_DIV=2'b00, DIVOP_DIVU=2'b01, DIVOP_REM=2'b10, DIVOP_REMU=2'b11.
- defines.v also gets the state encodings DIV_IDLE/DIV_CALC/DIV_FIX/DIV_DONE (2 bits) and the constant XLEN.
- EX-stage decode maps ALU_DIV/ALU_DIVU/ALU_REM/ALU_REMU onto start plus op.
- One natural combinational sub-module: div_step. Inputs rem, quo, divisor; outputs next rem and quo; isolates the 33-bit trial-subtract for unit test.

Test Plan:
- DIV a=-7 (32'hFFFFFFF9), b=2, start at cycle 0 -> stall high cycles 0..34, done at cycle 35, result=32'hFFFFFFFD (-3); REM on same operands -> 32'hFFFFFFFF (-1).
- DIVU a=32'hFFFFFFFF, b=16 -> result 32'h0FFFFFFF after 34 cycles; REMU same operands -> 32'h0000000F.
- Divide by zero: DIV a=123, b=0 -> done next cycle, result 32'hFFFFFFFF; REMU a=123, b=0 -> 123; stall high only for the start cycle.
- Overflow: DIV a=32'h80000000, b=32'hFFFFFFFF -> 32'h80000000 in 1 cycle; REM same operands -> 0.
- Abort: start DIV 100/7, flush asserted at cycle 10 -> IDLE at cycle 11, no done, result holds prior value. Then start 100/7 again -> 14 after 34 cycles. start+flush in the same IDLE cycle -> no acceptance, stall=0.
- Reset: drive rst low at cycle 20 of a divide -> outputs 0 immediately (async), no done. Also check that start pulses during CALC are ignored, and that a/b changes after acceptance do not alter the result.
